// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared types and constants for the SDRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;
    localparam int DS_W   = 2;

    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Round-robin successor over requesters 1..nreq-1 (requester 0 is never in the ring).
    function automatic logic [1:0] rr_next(input logic [1:0] winner, input int nreq);
        logic [1:0] last;
        last = 2'(nreq - 1);
        return (winner == last) ? 2'd1 : winner + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin search over requesters 1..NREQ-1,
//               starting at the pointer and wrapping back to 1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [3:0] i_valid,
    input  logic [1:0] i_ptr,
    output logic       o_found,
    output logic [1:0] o_winner
);

    localparam logic [2:0] LAST = 3'(NREQ - 1);

    logic [2:0] w_idx;
    logic       w_found;
    logic [1:0] w_winner;

    always_comb begin
        w_found  = 1'b0;
        w_winner = 2'd0;
        w_idx    = 3'd0;
        for (int k = 0; k < NREQ - 1; k++) begin
            w_idx = {1'b0, i_ptr} + 3'(k);
            if (w_idx > LAST) begin
                w_idx = w_idx - LAST;
            end
            if (!w_found && i_valid[w_idx[1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[1:0];
            end
        end
    end

    assign o_found  = w_found;
    assign o_winner = w_winner;

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter
// Description : Multi-requester arbiter in front of a toggle-handshake SDRAM
//               port; requester 0 has fixed priority, the rest round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_a,
    input  logic [NREQ*DS_W-1:0]   req_ds,
    input  logic [NREQ*DATA_W-1:0] req_d,
    output logic [NREQ-1:0]        req_done,
    output logic [DATA_W-1:0]      rdata,
    output logic                   sd_req,
    input  logic                   sd_ack,
    output logic                   sd_we,
    output logic [ADDR_W-1:0]      sd_a,
    output logic [DS_W-1:0]        sd_ds,
    output logic [DATA_W-1:0]      sd_d,
    input  logic [DATA_W-1:0]      sd_q,
    output logic                   busy,
    output logic [1:0]             grant_id,
    output logic                   err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    // Requester fields padded out to four slots so a 2-bit id always indexes in range.
    logic [3:0]        w_valid4;
    logic [3:0]        w_we4;
    logic [ADDR_W-1:0] w_a_arr  [4];
    logic [DS_W-1:0]   w_ds_arr [4];
    logic [DATA_W-1:0] w_d_arr  [4];

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        if (i < NREQ) begin : g_used
            assign w_valid4[i] = req_valid[i];
            assign w_we4[i]    = req_we[i];
            assign w_a_arr[i]  = req_a[i*ADDR_W +: ADDR_W];
            assign w_ds_arr[i] = req_ds[i*DS_W +: DS_W];
            assign w_d_arr[i]  = req_d[i*DATA_W +: DATA_W];
        end else begin : g_unused
            assign w_valid4[i] = 1'b0;
            assign w_we4[i]    = 1'b0;
            assign w_a_arr[i]  = '0;
            assign w_ds_arr[i] = '0;
            assign w_d_arr[i]  = '0;
        end
    end

    state_t            state_q,    state_d;
    logic              sd_req_q,   sd_req_d;
    logic              sd_we_q,    sd_we_d;
    logic [ADDR_W-1:0] sd_a_q,     sd_a_d;
    logic [DS_W-1:0]   sd_ds_q,    sd_ds_d;
    logic [DATA_W-1:0] sd_d_q,     sd_d_d;
    logic [1:0]        grant_id_q, grant_id_d;
    logic [1:0]        ptr_q,      ptr_d;
    logic [7:0]        cnt_q,      cnt_d;
    logic              err_q,      err_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic [NREQ-1:0]   req_done_q, req_done_d;

    logic       w_rr_found;
    logic [1:0] w_rr_winner;
    logic [1:0] w_winner;
    logic       w_any_valid;
    logic [3:0] w_done4;
    logic [7:0] w_cnt_inc;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .i_valid  (w_valid4),
        .i_ptr    (ptr_q),
        .o_found  (w_rr_found),
        .o_winner (w_rr_winner)
    );

    assign w_winner    = w_valid4[0] ? 2'd0 : w_rr_winner;
    assign w_any_valid = w_valid4[0] | w_rr_found;
    assign w_done4     = 4'b0001 << grant_id_q;
    assign w_cnt_inc   = cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        sd_req_d   = sd_req_q;
        sd_we_d    = sd_we_q;
        sd_a_d     = sd_a_q;
        sd_ds_d    = sd_ds_q;
        sd_d_d     = sd_d_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        req_done_d = '0;

        case (state_q)
            ST_IDLE: begin
                // A timeout pulse lands in IDLE while the aborted requester still
                // holds valid; granting it here would replay the aborted access.
                if (w_any_valid && (req_done_q == '0)) begin
                    grant_id_d = w_winner;
                    sd_we_d    = w_we4[w_winner];
                    sd_a_d     = w_a_arr[w_winner];
                    sd_ds_d    = w_ds_arr[w_winner];
                    sd_d_d     = w_d_arr[w_winner];
                    sd_req_d   = ~sd_req_q;
                    cnt_d      = 8'd0;
                    state_d    = ST_WAIT;
                    if (w_winner != 2'd0) begin
                        ptr_d = rr_next(w_winner, NREQ);
                    end
                end
            end
            ST_WAIT: begin
                if (sd_ack == sd_req_q) begin
                    if (!sd_we_q) begin
                        rdata_d = sd_q;
                    end
                    req_done_d = w_done4[NREQ-1:0];
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == TIMEOUT_CNT) begin
                        err_d      = 1'b1;
                        sd_req_d   = sd_ack;
                        rdata_d    = TIMEOUT_DATA;
                        req_done_d = w_done4[NREQ-1:0];
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sd_req_q   <= sd_ack;
            sd_we_q    <= 1'b0;
            sd_a_q     <= '0;
            sd_ds_q    <= '0;
            sd_d_q     <= '0;
            grant_id_q <= 2'd0;
            ptr_q      <= 2'd1;
            cnt_q      <= 8'd0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            req_done_q <= '0;
        end else begin
            state_q    <= state_d;
            sd_req_q   <= sd_req_d;
            sd_we_q    <= sd_we_d;
            sd_a_q     <= sd_a_d;
            sd_ds_q    <= sd_ds_d;
            sd_d_q     <= sd_d_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            req_done_q <= req_done_d;
        end
    end

    assign req_done = req_done_q;
    assign rdata    = rdata_q;
    assign sd_req   = sd_req_q;
    assign sd_we    = sd_we_q;
    assign sd_a     = sd_a_q;
    assign sd_ds    = sd_ds_q;
    assign sd_d     = sd_d_q;
    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_id_q;
    assign err      = err_q;

endmodule
`default_nettype wire
